// File: rtl/lab2_proc_mem_responder_pkg.sv
// ----------------------------------------------------------------------------
// lab2_proc_mem_responder_pkg
//
// Shared definitions for the memory responder and its storage array:
//   - request/response type codes (read, write, AMO add/and/or/swap)
//   - mem_req_4B_t / mem_resp_4B_t message structs
//   - len encoding (0 = full 4-byte word, 1..3 = that many bytes)
//   - responder FSM state type
//   - helpers for byte-lane enables and read masking
// ----------------------------------------------------------------------------
package lab2_proc_mem_responder_pkg;

    // Message type codes. Any other code is treated as unsupported.
    localparam logic [2:0] MEM_TYPE_READ     = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE    = 3'd1;
    localparam logic [2:0] MEM_TYPE_AMO_ADD  = 3'd3;
    localparam logic [2:0] MEM_TYPE_AMO_AND  = 3'd4;
    localparam logic [2:0] MEM_TYPE_AMO_OR   = 3'd5;
    localparam logic [2:0] MEM_TYPE_AMO_SWAP = 3'd6;

    // len field: 0 encodes a full word, otherwise the byte count.
    localparam logic [1:0] MEM_LEN_4B = 2'd0;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RESP  = 2'd2
    } resp_state_e;

    // Byte lanes touched by an access starting at byte offset 'off' for the
    // encoded length 'len'. Lanes beyond byte 3 simply fall off the word.
    function automatic logic [3:0] byte_en(input logic [1:0] off, input logic [1:0] len);
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] be;
        lo = {2'b00, off};
        hi = lo + ((len == MEM_LEN_4B) ? 4'd4 : {2'b00, len});
        for (int b = 0; b < 4; b++) begin
            be[b] = (4'(b) >= lo) && (4'(b) < hi);
        end
        return be;
    endfunction

    // Mask keeping the low 'len' bytes of a right-aligned read value.
    function automatic logic [31:0] len_mask(input logic [1:0] len);
        logic [31:0] m;
        case (len)
            2'd1:    m = 32'h0000_00FF;
            2'd2:    m = 32'h0000_FFFF;
            2'd3:    m = 32'h00FF_FFFF;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lab2_proc_mem_responder_array.sv
// ----------------------------------------------------------------------------
// lab2_proc_mem_responder_array
//
// Word-organised storage for the memory responder. Contents are never reset.
//   clk_i       clock; writes commit on its rising edge
//   idx_i       word index shared by the read and write paths
//   rdata_o     combinational read of the indexed word (pre-write value)
//   wen_i       byte-enabled write strobe
//   wbe_i       byte-lane enables for the write
//   wdata_i     write data, already shifted into its byte lanes
//   amo_en_i    atomic read-modify-write strobe (overrides wen_i)
//   amo_op_i    AMO type code selecting the combine function
//   amo_data_i  AMO operand
// ----------------------------------------------------------------------------
module lab2_proc_mem_responder_array
    import lab2_proc_mem_responder_pkg::*;
#(
    parameter int p_num_words = 256
) (
    input  logic                           clk_i,
    input  logic [$clog2(p_num_words)-1:0] idx_i,
    output logic [31:0]                    rdata_o,
    input  logic                           wen_i,
    input  logic [3:0]                     wbe_i,
    input  logic [31:0]                    wdata_i,
    input  logic                           amo_en_i,
    input  logic [2:0]                     amo_op_i,
    input  logic [31:0]                    amo_data_i
);

    logic [31:0] mem_q [p_num_words];
    logic [31:0] amo_result;

    assign rdata_o = mem_q[idx_i];

    always_comb begin
        amo_result = amo_data_i;
        case (amo_op_i)
            MEM_TYPE_AMO_ADD: amo_result = rdata_o + amo_data_i;
            MEM_TYPE_AMO_AND: amo_result = rdata_o & amo_data_i;
            MEM_TYPE_AMO_OR:  amo_result = rdata_o | amo_data_i;
            default:          amo_result = amo_data_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (amo_en_i) begin
            mem_q[idx_i] <= amo_result;
        end else if (wen_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/lab2_proc_mem_responder.sv
// ----------------------------------------------------------------------------
// lab2_proc_mem_responder
//
// Single-ported test memory with val/rdy request and response streams.
// The memory is accessed on the request-accept edge and the response is
// registered there, so a response is offered 1 + p_latency cycles later.
//
// Parameters:
//   p_num_words  number of 32-bit words (power of two, >= 4)
//   p_latency    extra cycles between accept and response valid
// Ports:
//   clk             clock
//   reset           asynchronous reset, active low
//   reqstream_val   request valid
//   reqstream_rdy   responder can accept a request
//   reqstream_msg   request (type, opaque, addr, len, data)
//   respstream_val  response valid
//   respstream_rdy  consumer can take the response
//   respstream_msg  response (type, opaque, test, len, data)
//
// Build option: define LAB2_PROC_MEM_RESPONDER_AMO_EN to enable the
// amo.add/and/or/swap types; otherwise they are treated as unsupported.
// ----------------------------------------------------------------------------
module lab2_proc_mem_responder
    import lab2_proc_mem_responder_pkg::*;
#(
    parameter int p_num_words = 256,
    parameter int p_latency   = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         reqstream_val,
    output logic         reqstream_rdy,
    input  mem_req_4B_t  reqstream_msg,
    output logic         respstream_val,
    input  logic         respstream_rdy,
    output mem_resp_4B_t respstream_msg
);

`ifdef LAB2_PROC_MEM_RESPONDER_AMO_EN
    localparam logic AMO_EN = 1'b1;
`else
    localparam logic AMO_EN = 1'b0;
`endif

    localparam int IDX_W = $clog2(p_num_words);
    localparam int CNT_W = (p_latency < 2) ? 1 : $clog2(p_latency);
    localparam logic [CNT_W-1:0] CNT_INIT = (p_latency > 0) ? CNT_W'(p_latency - 1) : '0;

    resp_state_e      state_q;
    logic [CNT_W-1:0] count_q;
    mem_resp_4B_t     resp_q;
    mem_resp_4B_t     resp_d;

    logic             req_fire;
    logic             resp_fire;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_off;
    logic [31:0]      rdata;
    logic             wen;
    logic             amo_en;
    logic [3:0]       wbe;
    logic [31:0]      wdata;

    // Address bits above the array size alias onto lower words.
    logic unused_addr_bits;
    assign unused_addr_bits = ^reqstream_msg.addr[31:IDX_W+2];

    // reqstream_rdy is gated by reset so nothing is accepted while reset is
    // held. With zero latency a new request may enter in RESP exactly when
    // the current response leaves, giving one transaction per cycle.
    always_comb begin
        reqstream_rdy = 1'b0;
        if (reset) begin
            case (state_q)
                ST_IDLE: reqstream_rdy = 1'b1;
                ST_RESP: reqstream_rdy = (p_latency == 0) ? respstream_rdy : 1'b0;
                default: reqstream_rdy = 1'b0;
            endcase
        end
    end

    assign respstream_val = (state_q == ST_RESP);
    assign respstream_msg = resp_q;

    assign req_fire  = reqstream_val && reqstream_rdy;
    assign resp_fire = respstream_val && respstream_rdy;

    assign word_idx = reqstream_msg.addr[IDX_W+1:2];
    assign byte_off = reqstream_msg.addr[1:0];

    lab2_proc_mem_responder_array #(
        .p_num_words (p_num_words)
    ) u_array (
        .clk_i      (clk),
        .idx_i      (word_idx),
        .rdata_o    (rdata),
        .wen_i      (wen),
        .wbe_i      (wbe),
        .wdata_i    (wdata),
        .amo_en_i   (amo_en),
        .amo_op_i   (reqstream_msg.type_),
        .amo_data_i (reqstream_msg.data)
    );

    // Response formation and memory strobes for the request on the inputs.
    // Reads see the word before any write on this same edge; AMOs return
    // the old full word.
    always_comb begin
        resp_d        = '0;
        resp_d.type_  = reqstream_msg.type_;
        resp_d.opaque = reqstream_msg.opaque;
        resp_d.len    = reqstream_msg.len;
        wen           = 1'b0;
        amo_en        = 1'b0;
        wbe           = byte_en(byte_off, reqstream_msg.len);
        wdata         = reqstream_msg.data << {byte_off, 3'b000};
        case (reqstream_msg.type_)
            MEM_TYPE_READ: begin
                resp_d.data = (rdata >> {byte_off, 3'b000}) & len_mask(reqstream_msg.len);
            end
            MEM_TYPE_WRITE: begin
                wen = req_fire;
            end
            MEM_TYPE_AMO_ADD, MEM_TYPE_AMO_AND, MEM_TYPE_AMO_OR, MEM_TYPE_AMO_SWAP: begin
                if (AMO_EN) begin
                    amo_en      = req_fire;
                    resp_d.data = rdata;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            resp_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        resp_q <= resp_d;
                        if (p_latency == 0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_DELAY;
                            count_q <= CNT_INIT;
                        end
                    end
                end
                ST_DELAY: begin
                    if (count_q == '0) begin
                        state_q <= ST_RESP;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_fire) begin
                        if (req_fire) begin
                            resp_q <= resp_d;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lab2_proc_mem_responder.sv
module tb_lab2_proc_mem_responder;
    import lab2_proc_mem_responder_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset = 1'b1;
    logic         req_val  [2];
    logic         req_rdy  [2];
    mem_req_4B_t  req_msg  [2];
    logic         resp_val [2];
    logic         resp_rdy [2];
    mem_resp_4B_t resp_msg [2];

    int passed = 0;
    int failed = 0;
    int total  = 0;

    mem_resp_4B_t exp_q [$];

    // Index 0: zero-latency responder. Index 1: three extra cycles.
    lab2_proc_mem_responder #(.p_num_words(256), .p_latency(0)) dut0 (
        .clk            (clk),
        .reset          (reset),
        .reqstream_val  (req_val[0]),
        .reqstream_rdy  (req_rdy[0]),
        .reqstream_msg  (req_msg[0]),
        .respstream_val (resp_val[0]),
        .respstream_rdy (resp_rdy[0]),
        .respstream_msg (resp_msg[0])
    );

    lab2_proc_mem_responder #(.p_num_words(256), .p_latency(3)) dut3 (
        .clk            (clk),
        .reset          (reset),
        .reqstream_val  (req_val[1]),
        .reqstream_rdy  (req_rdy[1]),
        .reqstream_msg  (req_msg[1]),
        .respstream_val (resp_val[1]),
        .respstream_rdy (resp_rdy[1]),
        .respstream_msg (resp_msg[1])
    );

    function automatic mem_req_4B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                           input logic [31:0] addr, input logic [1:0] len,
                                           input logic [31:0] data);
        mem_req_4B_t r;
        r.type_  = t;
        r.opaque = op;
        r.addr   = addr;
        r.len    = len;
        r.data   = data;
        return r;
    endfunction

    function automatic mem_resp_4B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                             input logic [1:0] len, input logic [31:0] data);
        mem_resp_4B_t r;
        r.type_  = t;
        r.opaque = op;
        r.test   = 2'd0;
        r.len    = len;
        r.data   = data;
        return r;
    endfunction

    function automatic logic [31:0] tog_data(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h0101_0101;
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on responder d with the response taken as
    // soon as it is offered. lat is the expected number of cycles between
    // the accept edge and respstream_val being visible.
    task automatic xact(input int d, input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] addr, input logic [1:0] len,
                        input logic [31:0] data, input logic [31:0] exp_data,
                        input int lat, input string tag);
        int n;
        logic rdy_low;
        @(negedge clk);
        req_msg[d]  = mk_req(t, op, addr, len, data);
        req_val[d]  = 1'b1;
        resp_rdy[d] = 1'b1;
        n = 0;
        #1;
        while (!req_rdy[d] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_accept"}, req_rdy[d], 1'b1);
        if (!req_rdy[d]) begin
            req_val[d] = 1'b0;
            return;
        end
        exp_q.push_back(mk_resp(t, op, len, exp_data));
        @(posedge clk);
        #1;
        req_val[d] = 1'b0;
        n = 0;
        rdy_low = 1'b1;
        while (!resp_val[d] && n < 20) begin
            if (req_rdy[d]) rdy_low = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        if (lat > 0) chk({tag, "_rdy_low"}, rdy_low, 1'b1);
        chk({tag, "_msg"}, resp_msg[d], exp_q.pop_front());
        @(posedge clk);
        #1;
        chk({tag, "_done"}, resp_val[d], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcvd;
        int cyc;

        for (int d = 0; d < 2; d++) begin
            req_val[d]  = 1'b0;
            req_msg[d]  = '0;
            resp_rdy[d] = 1'b1;
        end

        // Reset behaviour
        #1 reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_rdy%0d", d), req_rdy[d], 1'b0);
            chk($sformatf("rst_val%0d", d), resp_val[d], 1'b0);
            chk($sformatf("rst_msg%0d", d), resp_msg[d], '0);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold_rdy", req_rdy[0], 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_rise_rdy0", req_rdy[0], 1'b1);
        chk("rst_rise_rdy1", req_rdy[1], 1'b1);

        // Full-word and byte accesses, zero latency
        xact(0, MEM_TYPE_WRITE, 8'h11, 32'h200, 2'd0, 32'hDEAD_BEEF, 32'h0, 0, "wr_word");
        xact(0, MEM_TYPE_READ,  8'h12, 32'h200, 2'd0, 32'h0, 32'hDEAD_BEEF, 0, "rd_word");
        xact(0, MEM_TYPE_WRITE, 8'h13, 32'h201, 2'd1, 32'h0000_0055, 32'h0, 0, "wr_byte");
        xact(0, MEM_TYPE_READ,  8'h14, 32'h200, 2'd0, 32'h0, 32'hDEAD_55EF, 0, "rd_merged");
        xact(0, MEM_TYPE_READ,  8'h15, 32'h201, 2'd1, 32'h0, 32'h0000_0055, 0, "rd_byte");
        // Two bytes from offset 3: only byte 3 lands in the word
        xact(0, MEM_TYPE_WRITE, 8'h16, 32'h203, 2'd2, 32'h0000_AABB, 32'h0, 0, "wr_edge");
        xact(0, MEM_TYPE_READ,  8'h17, 32'h202, 2'd2, 32'h0, 32'h0000_BBAD, 0, "rd_half");
        xact(0, 3'd7,           8'h18, 32'h200, 2'd0, 32'hFFFF_FFFF, 32'h0, 0, "unsup");
        xact(0, MEM_TYPE_READ,  8'h19, 32'h200, 2'd0, 32'h0, 32'hBBAD_55EF, 0, "rd_after_unsup");

        // Address wrap-around and AMO
        xact(0, MEM_TYPE_WRITE, 8'h21, 32'h400, 2'd0, 32'd7, 32'h0, 0, "wrap_wr");
        xact(0, MEM_TYPE_READ,  8'h22, 32'h000, 2'd0, 32'h0, 32'd7, 0, "wrap_rd");
`ifdef LAB2_PROC_MEM_RESPONDER_AMO_EN
        xact(0, MEM_TYPE_AMO_ADD, 8'h23, 32'h000, 2'd0, 32'd5, 32'd7, 0, "amo_add");
        xact(0, MEM_TYPE_READ,    8'h24, 32'h000, 2'd0, 32'h0, 32'd12, 0, "amo_rd");
`else
        xact(0, MEM_TYPE_AMO_ADD, 8'h23, 32'h000, 2'd0, 32'd5, 32'd0, 0, "amo_add");
        xact(0, MEM_TYPE_READ,    8'h24, 32'h000, 2'd0, 32'h0, 32'd7, 0, "amo_rd");
`endif

        // Extra latency
        xact(1, MEM_TYPE_WRITE, 8'h51, 32'h40, 2'd0, 32'h1234_5678, 32'h0, 3, "l3_wr");
        xact(1, MEM_TYPE_READ,  8'h52, 32'h40, 2'd0, 32'h0, 32'h1234_5678, 3, "l3_rd");

        // Back-to-back reads with a toggling consumer
        for (int k = 0; k < 8; k++) begin
            xact(0, MEM_TYPE_WRITE, 8'(8'h30 + k), 32'(32'h300 + 4 * k), 2'd0, tog_data(k), 32'h0, 0, "tog_wr");
        end
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while ((sent < 8 || rcvd < 8) && cyc < 100) begin
            @(negedge clk);
            resp_rdy[0] = ((cyc % 2) != 0);
            if (sent < 8) begin
                req_val[0] = 1'b1;
                req_msg[0] = mk_req(MEM_TYPE_READ, 8'(8'h40 + sent), 32'(32'h300 + 4 * sent), 2'd0, 32'h0);
            end else begin
                req_val[0] = 1'b0;
            end
            #1;
            if (resp_val[0]) begin
                chk("tog_have_exp", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    chk("tog_msg", resp_msg[0], exp_q[0]);
                    if (resp_rdy[0]) begin
                        void'(exp_q.pop_front());
                        rcvd++;
                    end
                end
            end
            if (req_val[0] && req_rdy[0]) begin
                exp_q.push_back(mk_resp(MEM_TYPE_READ, 8'(8'h40 + sent), 2'd0, tog_data(sent)));
                sent++;
            end
            @(posedge clk);
            cyc++;
        end
        req_val[0]  = 1'b0;
        resp_rdy[0] = 1'b1;
        chk("tog_sent", sent, 8);
        chk("tog_rcvd", rcvd, 8);
        chk("tog_q_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("tog_idle", resp_val[0], 1'b0);

        // Reset while the delayed responder sits in DELAY
        @(negedge clk);
        req_msg[1] = mk_req(MEM_TYPE_WRITE, 8'h61, 32'h10, 2'd0, 32'hCAFE_F00D);
        req_val[1] = 1'b1;
        #1;
        chk("rstmid_accept", req_rdy[1], 1'b1);
        @(posedge clk);
        #1;
        req_val[1] = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rstmid_val", resp_val[1], 1'b0);
        chk("rstmid_rdy", req_rdy[1], 1'b0);
        chk("rstmid_msg", resp_msg[1], '0);
        @(posedge clk);
        #1;
        chk("rstmid_val_hold", resp_val[1], 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_rdy_back", req_rdy[1], 1'b1);
        chk("rstmid_no_resp", resp_val[1], 1'b0);
        xact(1, MEM_TYPE_READ, 8'h62, 32'h10, 2'd0, 32'h0, 32'hCAFE_F00D, 3, "rstmid_rd");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
